// File: rtl/constants.sv
// Shared design-wide constants.
package constants;
  localparam int WORD_LENGTH = 8;
endpackage

// File: rtl/_skid_buf.sv
// Two-entry valid/ready skid buffer: main register feeds out_data, the skid register
// catches the one word accepted while downstream stalls.
module _skid_buf #(
  parameter int n = constants::WORD_LENGTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [n-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [n-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]   r_state;
  logic [n-1:0] r_main;
  logic [n-1:0] r_skid;
  logic         w_in_xfer;
  logic         w_out_xfer;

  // Handshake outputs decode registered state only, so out_ready never reaches in_ready.
  assign in_ready   = (r_state == S_EMPTY) || (r_state == S_BUSY);
  assign out_valid  = (r_state == S_BUSY)  || (r_state == S_FULL);
  assign out_data   = r_main;
  assign count      = r_state;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_main  <= in_data;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= in_data;
          end else if (w_in_xfer) begin
            r_skid  <= in_data;
            r_state <= S_FULL;
          end else if (w_out_xfer) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_xfer) begin
            r_main  <= r_skid;
            r_state <= S_BUSY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb__skid_buf.sv
// Directed + random bench for _skid_buf with a queue scoreboard and decoupled monitor.
module tb__skid_buf;
  localparam int N = constants::WORD_LENGTH;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready = 1'b0;
  logic [1:0]   count;

  int total = 0;
  int bad   = 0;
  logic [N-1:0] sb[$];

  _skid_buf #(.n(N)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; checks happen on the negedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: sees the handshakes that the coming posedge will commit.
  always @(negedge clk) begin
    chk("count_le_2", {31'd0, (count <= 2'd2)}, 32'd1);
    chk("in_ready_decode", {31'd0, in_ready}, {31'd0, (count != 2'd2)});
    chk("out_valid_decode", {31'd0, out_valid}, {31'd0, (count != 2'd0)});
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  initial begin
    // Reset with handshakes active: nothing may be captured.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    step(); step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", {24'd0, out_data}, 32'h0);

    // Single word, minimum latency.
    in_valid = 1'b1; in_data = 8'h11; step();
    in_valid = 1'b0;
    chk("one_out_valid", {31'd0, out_valid}, 32'd1);
    chk("one_out_data", {24'd0, out_data}, 32'h11);
    chk("one_count", {30'd0, count}, 32'd1);
    chk("one_in_ready", {31'd0, in_ready}, 32'd1);

    // Fill to FULL, then a word that must be refused.
    in_valid = 1'b1; in_data = 8'h22; step();
    chk("full_count", {30'd0, count}, 32'd2);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_out_data", {24'd0, out_data}, 32'h11);
    in_data = 8'h33; step();
    chk("refuse_count", {30'd0, count}, 32'd2);
    chk("refuse_out_data", {24'd0, out_data}, 32'h11);
    in_valid = 1'b0; out_ready = 1'b1; step();
    chk("drain1_out_data", {24'd0, out_data}, 32'h22);
    chk("drain1_count", {30'd0, count}, 32'd1);
    step();
    chk("drain2_count", {30'd0, count}, 32'd0);
    chk("drain2_out_valid", {31'd0, out_valid}, 32'd0);

    // Streaming at full rate.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = N'(i); step();
      chk("stream_data", {24'd0, out_data}, i);
      chk("stream_count", {30'd0, count}, 32'd1);
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0; step();
    chk("stream_end_count", {30'd0, count}, 32'd0);

    // Flush from FULL discards a simultaneous output transfer.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hAA; step();
    in_data = 8'hBB; step();
    in_valid = 1'b0;
    chk("pre_flush_count", {30'd0, count}, 32'd2);
    flush = 1'b1; out_ready = 1'b1; step();
    flush = 1'b0;
    chk("flush_count", {30'd0, count}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    step(); step();
    chk("flush_no_bb", {31'd0, out_valid}, 32'd0);

    // Reset from FULL with both handshakes raised.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hCC; step();
    in_data = 8'hDD; step();
    chk("pre_rst_count", {30'd0, count}, 32'd2);
    rst = 1'b1; in_data = 8'hEE; out_ready = 1'b1; step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_count", {30'd0, count}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_data", {24'd0, out_data}, 32'h0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    step(); step();
    chk("mid_rst_no_stale", {31'd0, out_valid}, 32'd0);

    // Random traffic with occasional flush.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = N'($urandom);
      flush     = ($urandom_range(0, 63) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("rand_drain_count", {30'd0, count}, 32'd0);
    chk("rand_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
